// File: rtl/video_math_arb.sv
// Round-robin arbiter that lends one shared 12x12 multiplier and one 24/12 divider to NREQ requesters.
// Optional macro VIDEO_MATH_DIVZERO_EN: divide by zero bypasses the divider and returns 24'hFFFFFF.
module video_math_arb #(
   parameter int NREQ = 2
) (
   input  logic                 CLK_VIDEO,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      op,
   input  logic [24*NREQ-1:0]   arg_a,
   input  logic [12*NREQ-1:0]   arg_b,
   output logic [NREQ-1:0]      ack,
   output logic [23:0]          res,
   output logic                 busy,
   output logic                 mul_start,
   output logic [11:0]          mul_arg1,
   output logic [11:0]          mul_arg2,
   input  logic                 mul_run,
   input  logic [23:0]          mul_res,
   output logic                 div_start,
   output logic [23:0]          div_num,
   output logic [11:0]          div_den,
   input  logic                 div_run,
   input  logic [23:0]          div_res
);

   // state | meaning
   // IDLE  | waiting for a request while both engines are idle
   // ISSUE | one-cycle start pulse to the selected engine
   // WAIT  | waiting for the engine's run to drop (first cycle ignored)
   // DONE  | one-cycle ack to the granted requester
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   localparam int GW = $clog2(NREQ);

   state_t          state, state_nxt;
   logic [GW-1:0]   last_grant, grant_q, grant_sel;
   logic            grant_hit, can_grant;
   logic            sel_op, sel_dz;
   logic [23:0]     sel_a;
   logic [11:0]     sel_b;
   logic            op_q;
   logic [23:0]     a_q;
   logic [11:0]     b_q;
   logic            wait_armed;
   logic            eng_run;

   // search order starts one past the last winner
   always_comb begin
      grant_hit = 1'b0;
      grant_sel = '0;
      sel_op    = 1'b0;
      sel_a     = '0;
      sel_b     = '0;
      for (int k = 1; k <= NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!grant_hit && req[i] && (i == ((int'(last_grant) + k) % NREQ))) begin
               grant_hit = 1'b1;
               grant_sel = GW'(i);
               sel_op    = op[i];
               sel_a     = arg_a[24*i +: 24];
               sel_b     = arg_b[12*i +: 12];
            end
         end
      end
   end

`ifdef VIDEO_MATH_DIVZERO_EN
   assign sel_dz = sel_op && (sel_b == 12'd0);
`else
   assign sel_dz = 1'b0;
`endif

   assign can_grant = grant_hit && !mul_run && !div_run;
   assign eng_run   = op_q ? div_run : mul_run;

   always_ff @(posedge CLK_VIDEO) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (can_grant) state_nxt = sel_dz ? S_DONE : S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT:  if (wait_armed && !eng_run) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      ack       = '0;
      busy      = (state != S_IDLE);
      mul_start = 1'b0;
      div_start = 1'b0;
      case (state)
         S_ISSUE: begin
            mul_start = !op_q;
            div_start = op_q;
         end
         S_DONE:  ack[grant_q] = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge CLK_VIDEO) begin
      if (reset) begin
         last_grant <= GW'(NREQ-1);
         grant_q    <= '0;
         op_q       <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         res        <= '0;
         wait_armed <= 1'b0;
      end else begin
         if (state == S_IDLE && can_grant) begin
            grant_q <= grant_sel;
            op_q    <= sel_op;
            a_q     <= sel_a;
            b_q     <= sel_b;
            if (sel_dz) res <= 24'hFFFFFF;
         end
         // run is not yet valid in the first WAIT cycle
         wait_armed <= (state == S_WAIT);
         if (state == S_WAIT && wait_armed && !eng_run)
            res <= op_q ? div_res : mul_res;
         if (state == S_DONE)
            last_grant <= grant_q;
      end
   end

   assign mul_arg1 = a_q[11:0];
   assign mul_arg2 = b_q;
   assign div_num  = a_q;
   assign div_den  = b_q;

endmodule

// File: tb/tb_video_math_arb.sv
// Bench for video_math_arb: engine models, transaction-level reference model and directed vectors.
module tb_video_math_arb;

   localparam int NREQ = 2;
`ifdef VIDEO_MATH_DIVZERO_EN
   localparam bit DZ = 1'b1;
`else
   localparam bit DZ = 1'b0;
`endif

   logic              CLK_VIDEO = 1'b0;
   logic              reset = 1'b1;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ-1:0]   op = '0;
   logic [24*NREQ-1:0] arg_a = '0;
   logic [12*NREQ-1:0] arg_b = '0;
   logic [NREQ-1:0]   ack;
   logic [23:0]       res;
   logic              busy;
   logic              mul_start, div_start;
   logic [11:0]       mul_arg1, mul_arg2, div_den;
   logic [23:0]       div_num;
   logic              mul_run, div_run;
   logic [23:0]       mul_res = '0, div_res = '0;

   always #5 CLK_VIDEO = ~CLK_VIDEO;

   video_math_arb #(.NREQ(NREQ)) dut (
      .CLK_VIDEO(CLK_VIDEO), .reset(reset), .req(req), .op(op), .arg_a(arg_a), .arg_b(arg_b),
      .ack(ack), .res(res), .busy(busy),
      .mul_start(mul_start), .mul_arg1(mul_arg1), .mul_arg2(mul_arg2), .mul_run(mul_run), .mul_res(mul_res),
      .div_start(div_start), .div_num(div_num), .div_den(div_den), .div_run(div_run), .div_res(div_res)
   );

   int n_cmp = 0, n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // shared engine models: run rises the cycle after start and lasts *_len cycles
   int mul_len = 3, div_len = 5;
   int mul_cnt = 0, div_cnt = 0;
   always @(posedge CLK_VIDEO) begin
      if (mul_start) begin
         mul_cnt <= mul_len;
         mul_res <= {12'b0, mul_arg1} * {12'b0, mul_arg2};
      end else if (mul_cnt > 0) mul_cnt <= mul_cnt - 1;
      if (div_start) begin
         div_cnt <= div_len;
         div_res <= (div_den == 12'd0) ? 24'hFFFFFF : div_num / {12'b0, div_den};
      end else if (div_cnt > 0) div_cnt <= div_cnt - 1;
   end
   assign mul_run = (mul_cnt > 0);
   assign div_run = (div_cnt > 0);

   // reference model and per-cycle comparison
   int cyc = 0;
   bit m_busy = 0, m_op = 0, m_bp = 0, rst_seen = 0;
   int m_gk = 0, m_due = -1, m_idx = 0, m_last = NREQ-1, m_runcnt = 0;
   logic [23:0] m_a = '0, m_exp = '0, m_hold = '0;
   logic [11:0] m_b = '0;
   int ack_q[$];
   int n_ms = 0, n_ds = 0, acks_in_reset = 0, last_grant_cyc = 0, last_ack_cyc = 0;
   logic [11:0] cap_m1 = '0, cap_m2 = '0, cap_dd = '0;

   always @(negedge CLK_VIDEO) begin
      logic [NREQ-1:0] exp_ack;
      bit exp_ms, exp_ds, selrun, found;
      cyc++;
      if (mul_start) begin n_ms++; cap_m1 = mul_arg1; cap_m2 = mul_arg2; end
      if (div_start) begin n_ds++; cap_dd = div_den; end
      if (reset) begin
         if (ack != '0) acks_in_reset++;
         if (rst_seen) begin
            check("rst_ack", 32'(ack), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_mul_start", 32'(mul_start), 32'd0);
            check("rst_div_start", 32'(div_start), 32'd0);
            check("rst_res", 32'(res), 32'd0);
         end
         rst_seen = 1; m_busy = 0; m_last = NREQ-1; m_hold = '0;
      end else begin
         rst_seen = 0;
         exp_ack = (m_busy && cyc == m_due) ? (NREQ'(1) << m_idx) : '0;
         exp_ms  = m_busy && !m_bp && !m_op && cyc == m_gk + 1;
         exp_ds  = m_busy && !m_bp &&  m_op && cyc == m_gk + 1;
         check("ack", 32'(ack), 32'(exp_ack));
         check("mul_start", 32'(mul_start), 32'(exp_ms));
         check("div_start", 32'(div_start), 32'(exp_ds));
         check("busy", 32'(busy), 32'(m_busy && cyc > m_gk));
         if (m_busy && !m_bp && cyc > m_gk && cyc < m_due + (m_due < 0 ? 1000000 : 0)) begin
            check("mul_arg1", 32'(mul_arg1), 32'(m_a[11:0]));
            check("mul_arg2", 32'(mul_arg2), 32'(m_b));
            check("div_num", 32'(div_num), 32'(m_a));
            check("div_den", 32'(div_den), 32'(m_b));
         end
         if (exp_ack != '0) begin
            m_hold = m_exp;
            ack_q.push_back(m_idx);
            last_ack_cyc = cyc;
            check("latency", 32'(cyc - m_gk), m_bp ? 32'd1 : 32'(3 + m_runcnt));
         end
         check("res", 32'(res), 32'(m_hold));
         if (m_busy) begin
            if (cyc == m_due) begin
               m_busy = 0;
               m_last = m_idx;
            end else if (!m_bp && cyc >= m_gk + 2 && m_due < 0) begin
               selrun = m_op ? div_run : mul_run;
               if (selrun) m_runcnt++;
               else if (cyc >= m_gk + 3) m_due = cyc + 1;
            end
         end else if (req != '0 && !mul_run && !div_run) begin
            found = 0;
            for (int k = 1; k <= NREQ; k++) begin
               if (!found && req[(m_last + k) % NREQ]) begin
                  found = 1;
                  m_idx = (m_last + k) % NREQ;
               end
            end
            m_op  = op[m_idx];
            m_a   = arg_a[24*m_idx +: 24];
            m_b   = arg_b[12*m_idx +: 12];
            m_bp  = DZ && m_op && (m_b == 12'd0);
            m_exp = m_op ? ((m_b == 12'd0) ? 24'hFFFFFF : m_a / {12'b0, m_b})
                         : {12'b0, m_a[11:0]} * {12'b0, m_b};
            m_gk = cyc; m_due = m_bp ? cyc + 1 : -1; m_runcnt = 0; m_busy = 1;
            last_grant_cyc = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge CLK_VIDEO); #1;
   endtask

   task automatic wait_ack(input string name, output int idx);
      idx = -1;
      for (int t = 0; t < 200 && idx < 0; t++) begin
         @(negedge CLK_VIDEO); #1;
         if (ack != '0) idx = ack[1] ? 1 : 0;
      end
      if (idx < 0) begin
         n_cmp++; n_err++;
         $display("FAIL %s: got no ack expected ack within 200 cycles", name);
      end
   endtask

   // request, hold one cycle (granted), drop and scramble the operands, then wait for ack
   task automatic do_op(input string name, input int r, input bit o, input logic [23:0] a,
                        input logic [11:0] b, output int idx);
      op[r] = o; arg_a[24*r +: 24] = a; arg_b[12*r +: 12] = b; req[r] = 1'b1;
      tick();
      req[r] = 1'b0; op[r] = ~o;
      arg_a[24*r +: 24] = 24'($urandom); arg_b[12*r +: 12] = 12'($urandom_range(1, 4095));
      wait_ack(name, idx);
      tick();
   endtask

   initial begin
      int idx, ds0, ms0;
      repeat (3) tick();
      @(negedge CLK_VIDEO); #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_res", 32'(res), 32'd0);
      check("reset_ack", 32'(ack), 32'd0);
      tick();
      reset = 1'b0;
      tick();

      do_op("div_1080_400", 0, 1'b1, 24'd1080, 12'd400, idx);
      check("div_idx", 32'(idx), 32'd0);
      check("div_res", 32'(res), 32'd2);
      check("div_starts", 32'(n_ds), 32'd1);
      check("div_den_cap", 32'(cap_dd), 32'd400);
      check("div_latency", 32'(last_ack_cyc - last_grant_cyc), 32'd8);

      do_op("mul_400_2", 1, 1'b0, 24'h5A5190, 12'd2, idx);
      check("mul_idx", 32'(idx), 32'd1);
      check("mul_res", 32'(res), 32'd800);
      check("mul_arg1_cap", 32'(cap_m1), 32'd400);
      check("mul_arg2_cap", 32'(cap_m2), 32'd2);
      check("mul_no_div", 32'(n_ds), 32'd1);
      check("mul_starts", 32'(n_ms), 32'd1);

      do_op("mul_max", 0, 1'b0, 24'hFFFFFF, 12'hFFF, idx);
      check("mul_max_res", 32'(res), 32'hFFE001);
      do_op("div_max", 1, 1'b1, 24'hFFFFFF, 12'hFFF, idx);
      check("div_max_res", 32'(res), 32'd4097);

      ds0 = n_ds;
      do_op("div_zero", 1, 1'b1, 24'd1234, 12'd0, idx);
      check("divz_res", 32'(res), 32'hFFFFFF);
      check("divz_starts", 32'(n_ds - ds0), DZ ? 32'd0 : 32'd1);
      check("divz_latency", 32'(last_ack_cyc - last_grant_cyc), DZ ? 32'd1 : 32'd8);

      // both requesters held high from reset
      reset = 1'b1;
      req = 2'b11; op = 2'b10;
      arg_a = {24'd100, 24'd3}; arg_b = {12'd7, 12'd5};
      repeat (2) tick();
      ack_q.delete();
      reset = 1'b0;
      for (int n = 0; n < 4; n++) begin
         wait_ack("rr", idx);
         check("rr_idx", 32'(idx), 32'(n % 2));
         check("rr_res", 32'(res), (n % 2) ? 32'd14 : 32'd15);
      end
      tick();
      req = '0;
      check("rr_count", 32'(ack_q.size()), 32'd4);
      repeat (3) tick();

      // reset while the multiplier is still running
      mul_len = 30;
      op[0] = 1'b0; arg_a[23:0] = 24'd9; arg_b[11:0] = 12'd9; req[0] = 1'b1;
      tick();
      req[0] = 1'b0;
      repeat (6) tick();
      check("wait_busy", 32'(busy), 32'd1);
      acks_in_reset = 0;
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      mul_len = 3;
      ms0 = n_ms;
      arg_a[23:0] = 24'd7; arg_b[11:0] = 12'd6; req[0] = 1'b1;
      repeat (10) tick();
      check("held_off_start", 32'(n_ms - ms0), 32'd0);
      check("held_off_busy", 32'(busy), 32'd0);
      wait_ack("after_reset", idx);
      tick();
      req = '0;
      check("after_reset_idx", 32'(idx), 32'd0);
      check("after_reset_res", 32'(res), 32'd42);
      check("no_ack_in_reset", 32'(acks_in_reset), 32'd0);
      check("after_reset_start", 32'(n_ms - ms0), 32'd1);
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
